imem_uart_loader: RTL and testbench

- Boot-time instruction loader and the writer side of the pipeline's IMEM write port.
- Consumes a byte stream from the UART receiver over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory through imem_we/imem_waddr/imem_wdata.
- Asserts loader_done once the image length and checksum verify; loader_done feeds the core's loader_done_in.

---
 rtl/imem_uart_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed little-endian word
// stream from the UART receiver and writes it into instruction memory.
module imem_uart_loader #(
    parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        loader_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);
    localparam logic [31:0] TIMEOUT_C   = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_r, state_next_s;
    logic [1:0]  cnt_r, cnt_next_s;
    logic [31:0] len_r, len_next_s, len_full_s;
    logic [31:0] word_r, word_next_s;
    logic [7:0]  acc_r, acc_next_s;
    logic [31:0] timer_r, timer_next_s;
    logic [15:0] idx_r;
    logic        do_write_s, ready_next_s, accept_s, timeout_hit_s;
    logic        rx_ready_r, imem_we_r, loader_done_r, load_error_r;
    logic [31:0] imem_waddr_r, imem_wdata_r;

    assign accept_s      = rx_valid & rx_ready_r;
    assign timeout_hit_s = (TIMEOUT_C != 32'd0) && (timer_r == TIMEOUT_C - 32'd1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath next values; the length decision is taken on the
    // edge that accepts header byte 4, so no stray byte can slip in meanwhile.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        len_next_s   = len_r;
        word_next_s  = word_r;
        acc_next_s   = acc_r;
        timer_next_s = timer_r;
        do_write_s   = 1'b0;
        len_full_s   = {rx_data, len_r[31:8]};
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    len_next_s   = len_full_s;
                    cnt_next_s   = 2'd1;
                    timer_next_s = 32'd0;
                    state_next_s = S_LEN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    len_next_s   = len_full_s;
                    cnt_next_s   = cnt_r + 2'd1;
                    timer_next_s = 32'd0;
                    if (cnt_r != 2'd3) begin
                        state_next_s = S_LEN;
                    end else if (len_full_s == 32'd0) begin
                        state_next_s = S_DONE;
                    end else if (len_full_s > MAX_WORDS_C) begin
                        state_next_s = S_ERR;
                    end else begin
                        state_next_s = S_DATA;
                    end
                end else if (timeout_hit_s) begin
                    state_next_s = S_ERR;
                end else begin
                    timer_next_s = timer_r + 32'd1;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    word_next_s  = {rx_data, word_r[31:8]};
                    acc_next_s   = csum_update(acc_r, rx_data);
                    cnt_next_s   = cnt_r + 2'd1;
                    timer_next_s = 32'd0;
                    if (cnt_r == 2'd3) begin
                        do_write_s   = 1'b1;
                        state_next_s = S_WRITE;
                    end else begin
                        state_next_s = S_DATA;
                    end
                end else if (timeout_hit_s) begin
                    state_next_s = S_ERR;
                end else begin
                    timer_next_s = timer_r + 32'd1;
                end
            end
            S_WRITE: begin
                timer_next_s = 32'd0;
                // idx_r has already been bumped by the write itself
                if ({16'd0, idx_r} == len_r) begin
                    state_next_s = S_CSUM;
                end else begin
                    state_next_s = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept_s) begin
                    timer_next_s = 32'd0;
                    if (rx_data == acc_r) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_ERR;
                    end
                end else if (timeout_hit_s) begin
                    state_next_s = S_ERR;
                end else begin
                    timer_next_s = timer_r + 32'd1;
                end
            end
            S_DONE:  state_next_s = S_DONE;
            S_ERR:   state_next_s = S_ERR;
            default: state_next_s = S_ERR;
        endcase
    end

    // Ready is registered from the upcoming state so it always matches state_r
    always_comb begin
        ready_next_s = 1'b0;
        case (state_next_s)
            S_IDLE, S_LEN, S_DATA, S_CSUM: ready_next_s = 1'b1;
            default:                       ready_next_s = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r         <= 2'd0;
            len_r         <= 32'd0;
            word_r        <= 32'd0;
            acc_r         <= 8'd0;
            timer_r       <= 32'd0;
            idx_r         <= 16'd0;
            rx_ready_r    <= 1'b1;
            imem_we_r     <= 1'b0;
            imem_waddr_r  <= 32'd0;
            imem_wdata_r  <= 32'd0;
            loader_done_r <= 1'b0;
            load_error_r  <= 1'b0;
        end else begin
            cnt_r         <= cnt_next_s;
            len_r         <= len_next_s;
            word_r        <= word_next_s;
            acc_r         <= acc_next_s;
            timer_r       <= timer_next_s;
            rx_ready_r    <= ready_next_s;
            imem_we_r     <= do_write_s;
            loader_done_r <= (state_next_s == S_DONE);
            load_error_r  <= (state_next_s == S_ERR);
            if (do_write_s) begin
                imem_waddr_r <= IMEM_BASE + {14'd0, idx_r, 2'b00};
                imem_wdata_r <= word_next_s;
                idx_r        <= idx_r + 16'd1;
            end
        end
    end

    assign rx_ready     = rx_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_waddr   = imem_waddr_r;
    assign imem_wdata   = imem_wdata_r;
    assign loader_done  = loader_done_r;
    assign load_error   = load_error_r;
    assign words_loaded = idx_r;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader (MAX_WORDS=4, TIMEOUT_CYCLES=50).
module tb_imem_uart_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        loader_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    int ready_during_we = 0;
    int base_we;
    int rise_at;

    imem_uart_loader #(
        .IMEM_BASE      (32'h0000_0000),
        .MAX_WORDS      (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .loader_done  (loader_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            we_count++;
            if (rx_ready) ready_during_we++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        cycle();
        rst = 1'b1;
    endtask

    // Offers a byte and returns just after the edge that accepts it
    task automatic send_byte(input logic [7:0] b, input bit keep);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data = b;
        for (int i = 0; i < 8; i++) begin
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (ok) cycle();
        if (!keep) rx_valid = 1'b0;
        check("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_header(input logic [31:0] n, input bit keep);
        logic [31:0] v;
        v = n;
        for (int i = 0; i < 4; i++) begin
            if (!keep) cycle();
            send_byte(v[7:0], keep);
            v = v >> 8;
        end
    endtask

    // Sends one word and checks the write strobe one cycle after its 4th byte
    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit keep);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            if (!keep) cycle();
            send_byte(v[7:0], keep);
            v = v >> 8;
        end
        check("write_we", {31'd0, imem_we}, 32'd1);
        check("write_addr", imem_waddr, addr);
        check("write_data", imem_wdata, w);
        check("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_waddr", imem_waddr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_done", {31'd0, loader_done}, 32'd0);
        check("rst_error", {31'd0, load_error}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);

        // Nominal load with gaps; XOR of 13 05 A0 00 93 05 B0 00 is 0x90
        base_we = we_count;
        send_header(32'd2, 1'b0);
        send_word(32'h00A0_0513, 32'h0000_0000, 1'b0);
        cycle();
        check("hold_we", {31'd0, imem_we}, 32'd0);
        check("hold_addr", imem_waddr, 32'h0000_0000);
        check("hold_data", imem_wdata, 32'h00A0_0513);
        send_word(32'h00B0_0593, 32'h0000_0004, 1'b0);
        check("nom_words_at_write", {16'd0, words_loaded}, 32'd2);
        cycle();
        send_byte(8'h90, 1'b0);
        check("nom_done", {31'd0, loader_done}, 32'd1);
        check("nom_error", {31'd0, load_error}, 32'd0);
        check("nom_ready_done", {31'd0, rx_ready}, 32'd0);
        cycle();
        check("nom_words", {16'd0, words_loaded}, 32'd2);
        check("nom_we_count", we_count - base_we, 32'd2);

        // Bad checksum: words still written, then error
        do_reset();
        base_we = we_count;
        send_header(32'd2, 1'b0);
        send_word(32'h00A0_0513, 32'h0000_0000, 1'b0);
        send_word(32'h00B0_0593, 32'h0000_0004, 1'b0);
        cycle();
        send_byte(8'h08, 1'b0);
        check("badcs_error", {31'd0, load_error}, 32'd1);
        check("badcs_done", {31'd0, loader_done}, 32'd0);
        cycle();
        check("badcs_we_count", we_count - base_we, 32'd2);

        // Oversize length header
        do_reset();
        base_we = we_count;
        send_header(32'd5, 1'b0);
        check("over_error", {31'd0, load_error}, 32'd1);
        check("over_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (3) cycle();
        rx_valid = 1'b0;
        check("over_ready_held", {31'd0, rx_ready}, 32'd0);
        check("over_error_held", {31'd0, load_error}, 32'd1);
        check("over_we_count", we_count - base_we, 32'd0);

        // Full-width length compare
        do_reset();
        send_header(32'hFFFF_FFFF, 1'b0);
        check("maxlen_error", {31'd0, load_error}, 32'd1);

        // Largest legal length is not an error
        do_reset();
        send_header(32'd4, 1'b0);
        check("len4_error", {31'd0, load_error}, 32'd0);
        check("len4_ready", {31'd0, rx_ready}, 32'd1);

        // Zero-length image finishes without writes or checksum
        do_reset();
        base_we = we_count;
        send_header(32'd0, 1'b0);
        check("zero_done", {31'd0, loader_done}, 32'd1);
        check("zero_error", {31'd0, load_error}, 32'd0);
        cycle();
        check("zero_we_count", we_count - base_we, 32'd0);

        // Backpressure: rx_valid held high throughout
        do_reset();
        base_we = we_count;
        ready_during_we = 0;
        send_header(32'd2, 1'b1);
        send_word(32'h00A0_0513, 32'h0000_0000, 1'b1);
        send_word(32'h00B0_0593, 32'h0000_0004, 1'b1);
        send_byte(8'h90, 1'b0);
        check("bp_done", {31'd0, loader_done}, 32'd1);
        check("bp_error", {31'd0, load_error}, 32'd0);
        cycle();
        check("bp_words", {16'd0, words_loaded}, 32'd2);
        check("bp_we_count", we_count - base_we, 32'd2);
        check("bp_ready_in_write", ready_during_we, 32'd0);

        // Timeout 50 cycles after the last accepted byte
        do_reset();
        base_we = we_count;
        send_header(32'd1, 1'b0);
        cycle();
        send_byte(8'hAA, 1'b0);
        rise_at = -1;
        for (int i = 1; i <= 70; i++) begin
            cycle();
            if (load_error && rise_at < 0) rise_at = i;
        end
        check("to_rise_cycle", rise_at, 32'd50);
        check("to_done", {31'd0, loader_done}, 32'd0);
        check("to_we_count", we_count - base_we, 32'd0);

        // Reset mid-load, then a fresh one-word image
        do_reset();
        base_we = we_count;
        send_header(32'd3, 1'b0);
        send_word(32'h4433_2211, 32'h0000_0000, 1'b0);
        cycle();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        do_reset();
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd1);
        check("mid_rst_words", {16'd0, words_loaded}, 32'd0);
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        send_header(32'd1, 1'b0);
        send_word(32'hEFBE_ADDE, 32'h0000_0000, 1'b0);
        cycle();
        send_byte(8'h22, 1'b0);
        check("mid_done", {31'd0, loader_done}, 32'd1);
        check("mid_error", {31'd0, load_error}, 32'd0);
        cycle();
        check("mid_words", {16'd0, words_loaded}, 32'd1);
        check("mid_we_count", we_count - base_we, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
